// File: rtl/mvm_pkg.sv
// Shared types and arithmetic helpers for the streaming matrix-vector multiplier.
package mvm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_X,
        S_COMPUTE,
        S_OUTPUT
    } state_e;

    function automatic int acc_width(input int b, input int k);
        return 2 * b + $clog2(k);
    endfunction

    // Clamp v into the signed range of an ow-bit result when sat is set; otherwise
    // pass v through and let the caller keep the low ow bits.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int ow, input bit sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (sat && (v > hi)) return hi;
        if (sat && (v < lo)) return lo;
        return v;
    endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One MAC lane: private slice of A, registered read, product register,
// accumulator and the reduction of the row sum to 2B bits.
module mvm_mac_lane
    import mvm_pkg::*;
#(
    parameter int K   = 8,
    parameter int P   = 2,
    parameter int B   = 8,
    parameter int SAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_i,
    input  logic [$clog2(K*K/P)-1:0] waddr_i,
    input  logic [B-1:0]             wdata_i,
    input  logic [$clog2(K*K/P)-1:0] raddr_i,
    input  logic [B-1:0]             x_i,
    input  logic                     prod_en_i,
    input  logic                     acc_en_i,
    input  logic                     acc_clr_i,
    output logic [2*B-1:0]           res_o
);
    localparam int DEPTH = K * K / P;
    localparam int AW    = acc_width(B, K);

    logic [B-1:0]          mem_q [DEPTH];
    logic [B-1:0]          rd_q;
    logic signed [2*B-1:0] prod_q;
    logic signed [AW-1:0]  acc_q;
    logic signed [AW-1:0]  acc_sum;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rd_q <= mem_q[raddr_i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
        end else if (prod_en_i) begin
            prod_q <= $signed(rd_q) * $signed(x_i);
        end
    end

    assign acc_sum = acc_q + {{(AW-2*B){prod_q[2*B-1]}}, prod_q};

    always_ff @(posedge clk) begin
        if (reset || acc_clr_i) begin
            acc_q <= '0;
        end else if (acc_en_i) begin
            acc_q <= acc_sum;
        end
    end

    // acc_sum already folds in the last product, so the row result is ready on the group's final cycle.
    assign res_o = (2*B)'(sat_clamp(64'(acc_sum), 2 * B, SAT != 0));

endmodule

// File: rtl/mvm_stream.sv
// Streaming y = A*x core: load A / load x / compute over K/P row groups / stream y out.
// Handshake: a word moves on any rising edge where valid && ready; valid-side holds data stable until then.
module mvm_stream
    import mvm_pkg::*;
#(
    parameter int K   = 8,
    parameter int P   = 2,
    parameter int B   = 8,
    parameter int SAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           loadMatrix,
    input  logic           loadVector,
    input  logic           start,
    input  logic [B-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*B-1:0] out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           done,
    output state_e         dbg_state
);
    localparam int KW  = $clog2(K);
    localparam int CW  = $clog2(K * K);
    localparam int LAW = $clog2(K * K / P);
    localparam int NG  = K / P;
    localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
    localparam int JW  = $clog2(K + 2);

    state_e        state_q, state_d;
    logic [CW-1:0] a_cnt_q, a_cnt_d;
    logic [KW-1:0] x_cnt_q, x_cnt_d;
    logic [GW-1:0] g_q, g_d;
    logic [JW-1:0] j_q, j_d;
    logic [KW-1:0] o_cnt_q, o_cnt_d;
    logic          done_q, done_d;

    logic [B-1:0]   x_mem_q [K];
    logic [B-1:0]   x_rd_q;
    logic [2*B-1:0] y_q [K];
    logic [2*B-1:0] lane_res [P];

    logic           in_hs, out_hs, wr_a, wr_x;
    logic           in_compute, prod_en, acc_en, grp_end;
    logic [LAW-1:0] lane_waddr, lane_raddr;
    int             a_row, a_col;

    assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_X);
    assign out_valid = (state_q == S_OUTPUT);
    assign out_data  = out_valid ? y_q[o_cnt_q] : '0;
    assign done      = done_q;
    assign dbg_state = state_q;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign wr_a      = (state_q == S_LOAD_A) && in_hs && !reset;
    assign wr_x      = (state_q == S_LOAD_X) && in_hs && !reset;

    // Row i of A lives in lane i mod P; rows sharing a lane are stacked K words apart.
    always_comb begin
        a_row      = int'(a_cnt_q) / K;
        a_col      = int'(a_cnt_q) % K;
        lane_waddr = LAW'((a_row / P) * K + a_col);
        lane_raddr = LAW'(int'(g_q) * K + int'(j_q));
    end

    // Group cycle j: read at 0..K-1, product at 1..K, accumulate at 2..K, result out at K+1.
    assign in_compute = (state_q == S_COMPUTE);
    assign prod_en    = in_compute && (j_q >= JW'(1)) && (j_q <= JW'(K));
    assign acc_en     = in_compute && (j_q >= JW'(2)) && (j_q <= JW'(K));
    assign grp_end    = in_compute && (j_q == JW'(K + 1));

    for (genvar l = 0; l < P; l++) begin : g_lane
        mvm_mac_lane #(.K(K), .P(P), .B(B), .SAT(SAT)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .we_i      (wr_a && ((a_row % P) == l)),
            .waddr_i   (lane_waddr),
            .wdata_i   (in_data),
            .raddr_i   (lane_raddr),
            .x_i       (x_rd_q),
            .prod_en_i (prod_en),
            .acc_en_i  (acc_en),
            .acc_clr_i (!in_compute || grp_end),
            .res_o     (lane_res[l])
        );
    end

    always_comb begin
        state_d = state_q;
        a_cnt_d = a_cnt_q;
        x_cnt_d = x_cnt_q;
        g_d     = g_q;
        j_d     = j_q;
        o_cnt_d = o_cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COMPUTE;
                    g_d     = '0;
                    j_d     = '0;
                end else if (loadMatrix) begin
                    state_d = S_LOAD_A;
                    a_cnt_d = '0;
                end else if (loadVector) begin
                    state_d = S_LOAD_X;
                    x_cnt_d = '0;
                end
            end
            S_LOAD_A: begin
                if (in_hs) begin
                    if (a_cnt_q == CW'(K * K - 1)) begin
                        state_d = S_IDLE;
                        a_cnt_d = '0;
                    end else begin
                        a_cnt_d = a_cnt_q + 1'b1;
                    end
                end
            end
            S_LOAD_X: begin
                if (in_hs) begin
                    if (x_cnt_q == KW'(K - 1)) begin
                        state_d = S_IDLE;
                        x_cnt_d = '0;
                    end else begin
                        x_cnt_d = x_cnt_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                if (grp_end) begin
                    j_d = '0;
                    if (g_q == GW'(NG - 1)) begin
                        state_d = S_OUTPUT;
                        g_d     = '0;
                        o_cnt_d = '0;
                    end else begin
                        g_d = g_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_OUTPUT: begin
                if (out_hs) begin
                    if (o_cnt_q == KW'(K - 1)) begin
                        state_d = S_IDLE;
                        o_cnt_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        o_cnt_d = o_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_cnt_q <= '0;
            x_cnt_q <= '0;
            g_q     <= '0;
            j_q     <= '0;
            o_cnt_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_cnt_q <= a_cnt_d;
            x_cnt_q <= x_cnt_d;
            g_q     <= g_d;
            j_q     <= j_d;
            o_cnt_q <= o_cnt_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_x) x_mem_q[x_cnt_q] <= in_data;
        x_rd_q <= x_mem_q[KW'(j_q)];
        if (grp_end) begin
            for (int l = 0; l < P; l++) begin
                y_q[KW'(int'(g_q) * P + l)] <= lane_res[l];
            end
        end
    end

endmodule

// File: tb/tb_mvm_stream.sv
// Bench for mvm_stream: five configurations in two groups sharing stimulus (K=4 and K=8),
// table vectors, hand-written corner sequences and random runs against an arithmetic model.
module tb_mvm_stream;
    import mvm_pkg::*;

    localparam int NI = 5;
    int inst_k   [NI] = '{4, 4, 4, 8, 8};
    int inst_p   [NI] = '{2, 2, 4, 1, 8};
    int inst_sat [NI] = '{1, 0, 1, 1, 1};
    int inst_grp [NI] = '{0, 0, 0, 1, 1};

    logic       clk = 1'b0;
    logic       reset;
    logic       lm [2];
    logic       lv [2];
    logic       st [2];
    logic [7:0] in_data_g [2];
    logic       in_valid_g [2];
    logic       out_ready_g [2];

    logic        in_ready_w  [NI];
    logic        out_valid_w [NI];
    logic        done_w      [NI];
    logic [15:0] out_data_w  [NI];
    state_e      state_w     [NI];

    always #5 clk = ~clk;

    mvm_stream #(.K(4), .P(2), .B(8), .SAT(1)) u0 (
        .clk(clk), .reset(reset), .loadMatrix(lm[0]), .loadVector(lv[0]), .start(st[0]),
        .in_data(in_data_g[0]), .in_valid(in_valid_g[0]), .in_ready(in_ready_w[0]),
        .out_data(out_data_w[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready_g[0]),
        .done(done_w[0]), .dbg_state(state_w[0]));
    mvm_stream #(.K(4), .P(2), .B(8), .SAT(0)) u1 (
        .clk(clk), .reset(reset), .loadMatrix(lm[0]), .loadVector(lv[0]), .start(st[0]),
        .in_data(in_data_g[0]), .in_valid(in_valid_g[0]), .in_ready(in_ready_w[1]),
        .out_data(out_data_w[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready_g[0]),
        .done(done_w[1]), .dbg_state(state_w[1]));
    mvm_stream #(.K(4), .P(4), .B(8), .SAT(1)) u2 (
        .clk(clk), .reset(reset), .loadMatrix(lm[0]), .loadVector(lv[0]), .start(st[0]),
        .in_data(in_data_g[0]), .in_valid(in_valid_g[0]), .in_ready(in_ready_w[2]),
        .out_data(out_data_w[2]), .out_valid(out_valid_w[2]), .out_ready(out_ready_g[0]),
        .done(done_w[2]), .dbg_state(state_w[2]));
    mvm_stream #(.K(8), .P(1), .B(8), .SAT(1)) u3 (
        .clk(clk), .reset(reset), .loadMatrix(lm[1]), .loadVector(lv[1]), .start(st[1]),
        .in_data(in_data_g[1]), .in_valid(in_valid_g[1]), .in_ready(in_ready_w[3]),
        .out_data(out_data_w[3]), .out_valid(out_valid_w[3]), .out_ready(out_ready_g[1]),
        .done(done_w[3]), .dbg_state(state_w[3]));
    mvm_stream #(.K(8), .P(8), .B(8), .SAT(1)) u4 (
        .clk(clk), .reset(reset), .loadMatrix(lm[1]), .loadVector(lv[1]), .start(st[1]),
        .in_data(in_data_g[1]), .in_valid(in_valid_g[1]), .in_ready(in_ready_w[4]),
        .out_data(out_data_w[4]), .out_valid(out_valid_w[4]), .out_ready(out_ready_g[1]),
        .done(done_w[4]), .dbg_state(state_w[4]));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          rcv_n    [NI];
    logic [15:0] rcv      [NI][8];
    int          rcv_cyc  [NI][8];
    int          done_n   [NI];
    int          done_cyc [NI];
    int          comp_n   [NI];
    logic        prev_stall [NI];
    logic [15:0] prev_data  [NI];

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (prev_stall[i])
                chk($sformatf("hold_i%0d", i), {15'd0, out_valid_w[i], out_data_w[i]},
                    {16'd1, prev_data[i]});
            if (out_valid_w[i] && out_ready_g[inst_grp[i]]) begin
                if (rcv_n[i] < 8) begin
                    rcv[i][rcv_n[i]]     = out_data_w[i];
                    rcv_cyc[i][rcv_n[i]] = cyc;
                end
                rcv_n[i]++;
            end
            prev_stall[i] = out_valid_w[i] && !out_ready_g[inst_grp[i]];
            prev_data[i]  = out_data_w[i];
            if (done_w[i]) begin
                done_n[i]++;
                done_cyc[i] = cyc;
                chk($sformatf("done_idle_i%0d", i), 32'(state_w[i]), 32'(S_IDLE));
            end
            if (state_w[i] == S_COMPUTE) comp_n[i]++;
        end
    end

    // ---------------- drivers ----------------
    int ma [2][8][8];
    int mx [2][8];
    int wbuf [64];

    function automatic int gk(input int g);
        return (g == 0) ? 4 : 8;
    endfunction

    function automatic int rep(input int g);
        return (g == 0) ? 0 : 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cmd(input int g, input int which);
        lm[g] = (which == 0);
        lv[g] = (which == 1);
        st[g] = (which == 2);
        tick();
        lm[g] = 1'b0;
        lv[g] = 1'b0;
        st[g] = 1'b0;
    endtask

    task automatic load_words(input int g, input int which, input int n, input bit gaps, input bit noise);
        int idx = 0;
        int c = 0;
        pulse_cmd(g, which);
        while (idx < n && c < 400) begin
            in_valid_g[g] = !(gaps && (c % 3 == 2));
            in_data_g[g]  = 8'(wbuf[idx]);
            if (noise) begin
                lv[g] = 1'b1;
                st[g] = 1'b1;
            end
            if (in_valid_g[g] && in_ready_w[rep(g)]) idx++;
            tick();
            c++;
        end
        in_valid_g[g] = 1'b0;
        lv[g] = 1'b0;
        st[g] = 1'b0;
        chk($sformatf("load_words_g%0d", g), idx, n);
    endtask

    task automatic load_a(input int g, input bit gaps, input bit noise);
        for (int i = 0; i < gk(g); i++)
            for (int j = 0; j < gk(g); j++) wbuf[i * gk(g) + j] = ma[g][i][j];
        load_words(g, 0, gk(g) * gk(g), gaps, noise);
    endtask

    task automatic load_x(input int g);
        for (int j = 0; j < gk(g); j++) wbuf[j] = mx[g][j];
        load_words(g, 1, gk(g), 1'b0, 1'b0);
    endtask

    task automatic clear_mon(input int g);
        for (int i = 0; i < NI; i++)
            if (inst_grp[i] == g) begin
                rcv_n[i]  = 0;
                done_n[i] = 0;
                comp_n[i] = 0;
            end
    endtask

    // bp: 0 = out_ready high, 1 = alternating 0,1,..., 2 = random
    task automatic run(input int g, input int bp);
        int  c = 0;
        bit  all_done = 1'b0;
        clear_mon(g);
        pulse_cmd(g, 2);
        while (!all_done && c < 1000) begin
            out_ready_g[g] = (bp == 0) ? 1'b1 : (bp == 1) ? 1'(c % 2) : 1'($urandom_range(0, 1));
            tick();
            c++;
            all_done = 1'b1;
            for (int i = 0; i < NI; i++)
                if (inst_grp[i] == g && done_n[i] == 0) all_done = 1'b0;
        end
        out_ready_g[g] = 1'b0;
        chk($sformatf("run_finished_g%0d", g), 32'(all_done), 32'd1);
    endtask

    // ---------------- reference model and scoreboard ----------------
    logic [15:0] exp_q [$];

    function automatic logic [15:0] ref_y(input int g, input int row, input bit sat);
        longint s = 0;
        for (int j = 0; j < gk(g); j++) s += longint'(ma[g][row][j]) * longint'(mx[g][j]);
        if (sat && s > 32767) s = 32767;
        if (sat && s < -32768) s = -32768;
        return s[15:0];
    endfunction

    task automatic push_model(input int i);
        for (int r = 0; r < inst_k[i]; r++) exp_q.push_back(ref_y(inst_grp[i], r, inst_sat[i] != 0));
    endtask

    task automatic score(input int i, input string tag);
        int k = inst_k[i];
        chk($sformatf("%s_count_i%0d", tag, i), rcv_n[i], k);
        for (int r = 0; r < k; r++) begin
            if (exp_q.size() == 0) break;
            chk($sformatf("%s_y%0d_i%0d", tag, r, i), {16'd0, rcv[i][r]}, {16'd0, exp_q.pop_front()});
        end
        exp_q.delete();
        chk($sformatf("%s_compute_cycles_i%0d", tag, i), comp_n[i], (k / inst_p[i]) * (k + 2));
        chk($sformatf("%s_done_count_i%0d", tag, i), done_n[i], 1);
        chk($sformatf("%s_done_after_last_i%0d", tag, i), done_cyc[i], rcv_cyc[i][k-1] + 1);
    endtask

    task automatic rand_fill(input int g);
        for (int i = 0; i < gk(g); i++) begin
            for (int j = 0; j < gk(g); j++) ma[g][i][j] = int'($urandom_range(0, 255)) - 128;
            mx[g][i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // ---------------- table vectors (K=4 group) ----------------
    typedef struct {
        int          a [4][4];
        int          x [4];
        int          bp;
        logic [15:0] y_sat  [4];
        logic [15:0] y_wrap [4];
    } vec_t;
    vec_t tbl [3];

    task automatic use_table(input int t);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) ma[0][i][j] = tbl[t].a[i][j];
            mx[0][i] = tbl[t].x[i];
        end
    endtask

    task automatic push_table(input int t, input int i);
        for (int r = 0; r < 4; r++) exp_q.push_back(inst_sat[i] != 0 ? tbl[t].y_sat[r] : tbl[t].y_wrap[r]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].a      = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
        tbl[0].x      = '{1, 2, 3, 4};
        tbl[0].bp     = 0;
        tbl[0].y_sat  = '{16'd1, 16'd2, 16'd3, 16'd4};
        tbl[0].y_wrap = '{16'd1, 16'd2, 16'd3, 16'd4};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) tbl[1].a[i][j] = -128;
        tbl[1].x      = '{-128, -128, -128, -128};
        tbl[1].bp     = 0;
        tbl[1].y_sat  = '{16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff};
        tbl[1].y_wrap = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[2].a      = '{'{1, 0, 0, 0}, '{0, 2, 0, 0}, '{0, 0, 3, 0}, '{0, 0, 0, 4}};
        tbl[2].x      = '{5, 5, 5, 5};
        tbl[2].bp     = 1;
        tbl[2].y_sat  = '{16'd5, 16'd10, 16'd15, 16'd20};
        tbl[2].y_wrap = '{16'd5, 16'd10, 16'd15, 16'd20};

        for (int i = 0; i < NI; i++) prev_stall[i] = 1'b0;
        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            lm[g] = 1'b0; lv[g] = 1'b0; st[g] = 1'b0;
            in_data_g[g] = '0; in_valid_g[g] = 1'b0; out_ready_g[g] = 1'b0;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_in_ready_i%0d", i), 32'(in_ready_w[i]), 32'd0);
            chk($sformatf("rst_out_valid_i%0d", i), 32'(out_valid_w[i]), 32'd0);
            chk($sformatf("rst_out_data_i%0d", i), 32'(out_data_w[i]), 32'd0);
            chk($sformatf("rst_done_i%0d", i), 32'(done_w[i]), 32'd0);
            chk($sformatf("rst_state_i%0d", i), 32'(state_w[i]), 32'(S_IDLE));
        end

        // identity, overflow, backpressure
        for (int t = 0; t < 3; t++) begin
            use_table(t);
            load_a(0, 1'b0, 1'b0);
            load_x(0);
            run(0, tbl[t].bp);
            for (int i = 0; i < 3; i++) begin
                push_table(t, i);
                score(i, $sformatf("tbl%0d", t));
            end
            if (tbl[t].bp == 0)
                for (int k = 1; k < 4; k++)
                    chk($sformatf("tbl%0d_consecutive_%0d", t, k), rcv_cyc[0][k], rcv_cyc[0][0] + k);
        end

        // input gaps with commands asserted during LOAD_A
        use_table(2);
        load_a(0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("gap_state_after_load_i%0d", i), 32'(state_w[i]), 32'(S_IDLE));
            chk($sformatf("gap_in_ready_after_load_i%0d", i), 32'(in_ready_w[i]), 32'd0);
        end
        load_x(0);
        run(0, 0);
        for (int i = 0; i < 3; i++) begin
            push_table(2, i);
            score(i, "gap");
        end

        // reset during COMPUTE, then reuse the retained A with x = ones
        rand_fill(0);
        load_a(0, 1'b0, 1'b0);
        load_x(0);
        clear_mon(0);
        pulse_cmd(0, 2);
        repeat (3) tick();
        chk("midreset_in_compute", 32'(state_w[0]), 32'(S_COMPUTE));
        reset = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midreset_state_i%0d", i), 32'(state_w[i]), 32'(S_IDLE));
            chk($sformatf("midreset_out_valid_i%0d", i), 32'(out_valid_w[i]), 32'd0);
        end
        reset = 1'b0;
        for (int j = 0; j < 4; j++) mx[0][j] = 1;
        load_x(0);
        run(0, 2);
        for (int i = 0; i < 3; i++) begin
            push_model(i);
            score(i, "rowsum");
        end

        // random runs on both groups against the model
        for (int n = 0; n < 3; n++) begin
            for (int g = 0; g < 2; g++) begin
                rand_fill(g);
                load_a(g, 1'b0, 1'b0);
                load_x(g);
                run(g, (n == 0) ? 0 : 2);
                for (int i = 0; i < NI; i++)
                    if (inst_grp[i] == g) begin
                        push_model(i);
                        score(i, $sformatf("rand%0d", n));
                    end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mvm_stream.md
# mvm_stream

Parametrised matrix-vector multiplier computing y = A·x for a K×K signed matrix and K-element signed vector, using P parallel multiply-accumulate lanes. It replaces the fixed-size, per-configuration MVM generator output as the single reusable core of the accelerator datapath. Operands enter through one valid/ready input stream, results leave through a valid/ready output stream, and overflow is handled by an optional saturation mode.

## Interface

**Parameters**
- K, 8: matrix dimension. Power of two, ≥2.
- P, 2: parallel MAC lanes. Power of two; P divides K.
- B, 8: operand width, signed two's complement.
- SAT, 1: output overflow mode. 1 = saturate to the output range; 0 = wrap (truncate).

**Ports** (clock and reset first)
- clk, in, 1: sole clock; all logic is on the rising edge.
- reset, in, 1: synchronous, active-high.
- loadMatrix, in, 1: command to load A; sampled only in IDLE.
- loadVector, in, 1: command to load x; sampled only in IDLE.
- start, in, 1: command to compute and stream y; sampled only in IDLE.
- in_data, in, B: operand word.
- in_valid, in, 1: in_data is valid.
- in_ready, out, 1: block accepts in_data. Asserted only in LOAD_A and LOAD_X.
- out_data, out, 2B: result element, signed.
- out_valid, out, 1: out_data is valid.
- out_ready, in, 1: downstream accepts out_data.
- done, out, 1: one-cycle pulse on the cycle after the last output handshake.

## Operation

- **Command priority in IDLE:** start > loadMatrix > loadVector. Commands in any other state are ignored.
- **States:** IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT.
  - IDLE→LOAD_A on loadMatrix, →LOAD_X on loadVector, →COMPUTE on start.
  - LOAD_A→IDLE after K·K handshakes.
  - LOAD_X→IDLE after K handshakes.
  - COMPUTE→OUTPUT after the last row group completes.
  - OUTPUT→IDLE after K output handshakes.
- **Loading A:** row-major; one word transfers per cycle where in_valid && in_ready.
  - Element A[i][j] is written to lane (i mod P) at address (i/P)·K + j.
  - Lane memories hold K·K/P words each, with 1-cycle registered read.
- **Loading x:** K words into the x memory at addresses 0..K-1.
- **Gaps in input:** in_valid low stalls the load counters; no word is lost or duplicated.
- **COMPUTE:** K/P row groups processed in order.
  - Per group: j = 0..K-1 is read from all lanes and from x; lane l accumulates A[g·P+l][j]·x[j].
  - Accumulators are cleared at group start.
- **Arithmetic:**
  - Product is 2B bits, full precision.
  - Accumulator is 2B+log2(K) bits; accumulation never overflows internally.
  - At group end each accumulator is reduced to 2B bits and written to the y register file at index g·P+l.
  - SAT=1: clamp to [−2^(2B−1), 2^(2B−1)−1].
  - SAT=0: keep the low 2B bits.
- **OUTPUT:**
  - y[0..K-1] is presented in order.
  - out_data and out_valid hold stable while out_valid && !out_ready.
  - The index advances only on handshake.
- **Retention:** A and x persist across computations and across reset; reset clears no memory. Reloading x alone and issuing start reuses the stored A.

## Timing

- **Reset values:** in_ready=0, out_valid=0, out_data=0, done=0. State is IDLE and all counters are 0.
- **Reset mid-operation:** the block is in IDLE on the next cycle and any partial load or computation is abandoned.
- **in_ready** asserts the cycle after the LOAD_A/LOAD_X transition and deasserts in the cycle after the final handshake.
- **COMPUTE duration:** exactly (K/P)·(K+2) cycles. Each group takes K read cycles, plus 1 memory latency, plus 1 MAC register stage.
- **Output start:** out_valid first asserts the cycle after COMPUTE ends.
- **Output rate:** with out_ready held high, K consecutive results are produced, one per cycle.
- **done:** pulses the cycle after the K-th handshake, coincident with the return to IDLE. A new command is accepted in that same cycle.
- **Simultaneous commands:** priority as given under Operation.
- **Counter wrap:** no counter wraps. Load counters stop at their terminal count and the FSM leaves the state.

## Structure

- **Package mvm_pkg:**
  - state enum typedef.
  - Functions for accumulator width (2B+$clog2(K)) and the saturation clamp.
- **Sub-module mvm_mac_lane:** instantiated P times. Each instance contains:
  - its lane memory (K·K/P × B);
  - the product register;
  - the accumulator with clear and enable;
  - the reduce-to-2B logic.
- **Top level:** FSM, counters, x memory, y register file and stream handshakes.

## Test plan

Default configuration for scenarios 1–5: K=4, P=2, B=8.

1. **Identity:** load A=I, then x=[1,2,3,4], then start with out_ready=1 → out_data 1,2,3,4 on consecutive cycles; done one cycle later; COMPUTE lasts 12 cycles.
2. **Overflow:** all A=−128, x=−128, so each sum is 65536.
   - SAT=1 → all outputs 32767.
   - SAT=0 → all outputs 0.
3. **Backpressure:** A rows [1,0,0,0],[0,2,0,0],[0,0,3,0],[0,0,0,4] with x=[5,5,5,5]; out_ready pattern 0,1,0,1,… → outputs 5,10,15,20, each held stable while stalled; done after the 4th handshake only.
4. **Input gaps:** load A with in_valid low on every third cycle → results identical to the gap-free case. Commands asserted during LOAD_A are ignored.
5. **Reset and reuse:**
   - Assert reset during COMPUTE → IDLE next cycle, out_valid=0.
   - Then reload only x=[1,1,1,1] and start → each y[i] equals row sum i of the retained A.
6. **Configuration sweep:** (K,P) ∈ {(8,1),(8,8),(4,4)} with random A and x compared against a reference model → bit-exact results, with COMPUTE duration equal to (K/P)·(K+2) cycles.
